// File: rtl/ev_cmd_arbiter_if.sv
// Request channels from the PLC and HMI masters into the EV command arbiter.
// Each channel is a valid/ready handshake carrying a 3-bit op and 4-bit arg.
interface ev_cmd_arbiter_if;
  logic       plc_req_valid;
  logic [2:0] plc_req_op;
  logic [3:0] plc_req_arg;
  logic       plc_req_ready;
  logic       hmi_req_valid;
  logic [2:0] hmi_req_op;
  logic [3:0] hmi_req_arg;
  logic       hmi_req_ready;

  modport master (
    output plc_req_valid, plc_req_op, plc_req_arg,
    input  plc_req_ready,
    output hmi_req_valid, hmi_req_op, hmi_req_arg,
    input  hmi_req_ready
  );

  modport slave (
    input  plc_req_valid, plc_req_op, plc_req_arg,
    output plc_req_ready,
    input  hmi_req_valid, hmi_req_op, hmi_req_arg,
    output hmi_req_ready
  );
endinterface

// File: rtl/ev_cmd_arbiter.sv
// Two-master command arbiter for the EV motor core: mode-based priority with a
// starvation guard, fixed hold window per op, and idle-time speed/PWM refresh.
module ev_cmd_arbiter #(
  parameter int unsigned HOLD_CYCLES    = 4,
  parameter int unsigned REFRESH_PERIOD = 256
) (
  input  logic               clk,
  input  logic               rst,
  ev_cmd_arbiter_if.slave    req,
  input  logic               mode_select,
  output logic [2:0]         core_op_sel,
  output logic [3:0]         core_arg,
  output logic               core_src,
  output logic               busy,
  output logic               refresh_active,
  output logic               cmd_done
);

  localparam logic [3:0]  HOLD_LOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [15:0] IDLE_LAST = 16'(REFRESH_PERIOD - 1);
  localparam logic [2:0]  OP_RESET  = 3'b110;
  localparam logic [2:0]  OP_SPD    = 3'b100;
  localparam logic [2:0]  OP_PWM    = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_REF_SPD = 2'd2,
    ST_REF_PWM = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  hold_cnt_r, hold_cnt_s;
  logic [15:0] idle_cnt_r, idle_cnt_s;
  logic [1:0]  loss_cnt_r, loss_cnt_s;
  logic        mode_prev_r, mode_prev_s;
  logic [2:0]  core_op_sel_r, op_s;
  logic [3:0]  core_arg_r, arg_s;
  logic        core_src_r, src_s;
  logic        busy_r, refresh_active_r, cmd_done_r;
  logic        plc_ready_s, hmi_ready_s;

  logic        pri_valid_s, npri_valid_s;
  logic        grant_any_s, grant_hmi_s;
  logic [1:0]  loss_eff_s, loss_next_s;

  // Winner selection; a mode change since the last IDLE cycle forgets past losses.
  always_comb begin
    pri_valid_s  = mode_select ? req.hmi_req_valid : req.plc_req_valid;
    npri_valid_s = mode_select ? req.plc_req_valid : req.hmi_req_valid;
    loss_eff_s   = (mode_select != mode_prev_r) ? 2'd0 : loss_cnt_r;
    grant_any_s  = 1'b0;
    grant_hmi_s  = 1'b0;
    loss_next_s  = loss_eff_s;
    if (pri_valid_s && npri_valid_s) begin
      grant_any_s = 1'b1;
      if (loss_eff_s == 2'd3) begin
        grant_hmi_s = ~mode_select;
        loss_next_s = 2'd0;
      end else begin
        grant_hmi_s = mode_select;
        loss_next_s = loss_eff_s + 2'd1;
      end
    end else if (pri_valid_s) begin
      grant_any_s = 1'b1;
      grant_hmi_s = mode_select;
    end else if (npri_valid_s) begin
      grant_any_s = 1'b1;
      grant_hmi_s = ~mode_select;
      loss_next_s = 2'd0;
    end else begin
      grant_any_s = 1'b0;
    end
  end

  // Next-state logic and the values loaded into the core-facing registers.
  always_comb begin
    state_s     = state_r;
    hold_cnt_s  = hold_cnt_r;
    idle_cnt_s  = idle_cnt_r;
    loss_cnt_s  = loss_cnt_r;
    mode_prev_s = mode_prev_r;
    op_s        = core_op_sel_r;
    arg_s       = core_arg_r;
    src_s       = core_src_r;
    plc_ready_s = 1'b0;
    hmi_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        mode_prev_s = mode_select;
        loss_cnt_s  = loss_next_s;
        plc_ready_s = grant_any_s & ~grant_hmi_s;
        hmi_ready_s = grant_any_s & grant_hmi_s;
        if (grant_any_s) begin
          state_s    = ST_HOLD;
          hold_cnt_s = HOLD_LOAD;
          idle_cnt_s = 16'd0;
          op_s       = grant_hmi_s ? req.hmi_req_op  : req.plc_req_op;
          arg_s      = grant_hmi_s ? req.hmi_req_arg : req.plc_req_arg;
          src_s      = grant_hmi_s;
        end else if (idle_cnt_r == IDLE_LAST) begin
          state_s    = ST_REF_SPD;
          hold_cnt_s = HOLD_LOAD;
          idle_cnt_s = 16'd0;
          op_s       = OP_SPD;
        end else begin
          idle_cnt_s = idle_cnt_r + 16'd1;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_r == 4'd0) begin
          state_s = ST_IDLE;
        end else begin
          hold_cnt_s = hold_cnt_r - 4'd1;
        end
      end
      ST_REF_SPD: begin
        if (hold_cnt_r == 4'd0) begin
          state_s    = ST_REF_PWM;
          hold_cnt_s = HOLD_LOAD;
          op_s       = OP_PWM;
        end else begin
          hold_cnt_s = hold_cnt_r - 4'd1;
        end
      end
      ST_REF_PWM: begin
        if (hold_cnt_r == 4'd0) begin
          state_s = ST_IDLE;
        end else begin
          hold_cnt_s = hold_cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; status flags follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      hold_cnt_r       <= 4'd0;
      idle_cnt_r       <= 16'd0;
      loss_cnt_r       <= 2'd0;
      mode_prev_r      <= 1'b0;
      core_op_sel_r    <= OP_RESET;
      core_arg_r       <= 4'd0;
      core_src_r       <= 1'b0;
      busy_r           <= 1'b0;
      refresh_active_r <= 1'b0;
      cmd_done_r       <= 1'b0;
    end else begin
      state_r          <= state_s;
      hold_cnt_r       <= hold_cnt_s;
      idle_cnt_r       <= idle_cnt_s;
      loss_cnt_r       <= loss_cnt_s;
      mode_prev_r      <= mode_prev_s;
      core_op_sel_r    <= op_s;
      core_arg_r       <= arg_s;
      core_src_r       <= src_s;
      busy_r           <= (state_s != ST_IDLE);
      refresh_active_r <= (state_s == ST_REF_SPD) || (state_s == ST_REF_PWM);
      cmd_done_r       <= (state_s == ST_HOLD) && (hold_cnt_s == 4'd0);
    end
  end

  assign req.plc_req_ready = plc_ready_s;
  assign req.hmi_req_ready = hmi_ready_s;
  assign core_op_sel       = core_op_sel_r;
  assign core_arg          = core_arg_r;
  assign core_src          = core_src_r;
  assign busy              = busy_r;
  assign refresh_active    = refresh_active_r;
  assign cmd_done          = cmd_done_r;

endmodule
